nx_ram_fifo_1rw_ctrl: RTL
=========================

# nx_ram_fifo_1rw_ctrl

FIFO controller that turns one single-port 1rw RAM macro into a valid/ready FIFO. It sits directly upstream of the 1rw RAM wrapper: it drives the RAM's `cs`/`we`/`add`/`din`/`bwe` and consumes its registered `dout`. A 3-entry output prefetch buffer hides the 1-cycle RAM read latency. Writes and prefetch reads share the single RAM port under a fixed arbitration rule.

## Interface
- `WIDTH`, 64: data width.
- `DEPTH`, 32768: RAM entries; any value ≥ 2, power of two not required.
- `AW`, 15: RAM address width; `$clog2(DEPTH)`.
- `clk` in 1: clock; also clocks the RAM.
- `rst_n` in 1: asynchronous active-low reset.
- `wr_valid` in 1: write request.
- `wr_data` in WIDTH: write data.
- `wr_ready` out 1: write accepted when `wr_valid && wr_ready`.
- `rd_valid` out 1: head-of-FIFO valid.
- `rd_data` out WIDTH: head-of-FIFO data.
- `rd_ready` in 1: pop when `rd_valid && rd_ready`.
- `level` out AW+2: total entries held (RAM + in-flight + output buffer).
- `ram_cs`, `ram_we` out 1: RAM strobes.
- `ram_add` out AW: RAM address.
- `ram_din`, `ram_bwe` out WIDTH: write data; `ram_bwe` is constant all ones.
- `ram_dout` in WIDTH: RAM registered read data, valid 1 cycle after a read strobe.
- `ram_ecc_err` in 1: RAM uncorrectable-error flag.
- `err` out 1: sticky error.
- `err_addr` out AW: address of the first errored read.

## Operation
- **RAM-side state:** `wptr` and `rptr` are AW bits and wrap from DEPTH-1 to 0. `ram_count` is AW+1 bits and counts entries in RAM that have not been fetched yet.
- **Prefetch state:** `inflight` is 1 bit (read issued last cycle). `ob_count` is 0..3, for a 3-entry output FIFO.
- **Fetch request:** `fetch_req = (ram_count != 0) && (ob_count + inflight < 3)`.
- **Urgent fetch:** `urgent = fetch_req && ob_count == 0 && !inflight`.
- **Write ready:** `wr_ready = (ram_count != DEPTH) && !(fetch_req && (urgent || last_grant == WR))`. `wr_ready` must not depend combinationally on `wr_valid` or `rd_ready`.
- **Write grant:** `wr_valid && wr_ready`. Drive `ram_cs=1`, `ram_we=1`, `ram_add=wptr`, `ram_din=wr_data`. Then increment `wptr` and increment `ram_count`.
- **Fetch grant:** `fetch_req && !(write grant)`. Drive `ram_cs=1`, `ram_we=0`, `ram_add=rptr`. Then increment `rptr`, decrement `ram_count`, and set `inflight`.
- **Arbitration:** `last_grant` records the most recent grant, WR or RD. When both requesters are non-urgent, they alternate.
- **Idle:** when neither grant occurs, `ram_cs=0`. `ram_add` and `ram_din` are don't-care.
- **Landing:** when `inflight` was set, `ram_dout` is pushed into the output buffer this cycle.
- **Output side:** `rd_valid = ob_count != 0`. `rd_data` is the buffer head.
- **Simultaneous push and pop:** a landing push and a pop in the same cycle leave `ob_count` unchanged.
- **Level:** `level = ram_count + inflight + ob_count`, in AW+2 bits so it can reach DEPTH+3.
- **Write + fetch same cycle:** cannot happen. The arbiter grants exactly one requester.
- **Full:** at `ram_count == DEPTH`, `wr_ready=0` while prefetching continues. Capacity is therefore DEPTH+3 entries.

## Timing
- **Reset values:** on `rst_n` low, asynchronously clear `wptr`, `rptr`, `ram_count`, `inflight`, `ob_count`, `err` and `err_addr`, and set `last_grant=RD`. Outputs then read `wr_ready=1`, `rd_valid=0`, `level=0`, `ram_cs=0`, `ram_we=0`, `err=0`.
- **Reset mid-operation:** all queued data is discarded. RAM contents are not cleared.
- **Write-to-read latency on an empty FIFO:**
  - write accepted at edge E0;
  - urgent fetch issued in the cycle after E0, sampled at E1;
  - data lands at E2;
  - `rd_valid=1` after E2.
- **Pop throughput:** with no writes pending, the FIFO pops every cycle.
- **Mixed throughput:** with continuous writes and continuous pops, each side averages 1 transfer per 2 cycles.

## Configuration
- **Macro:** `NX_RAM_FIFO_1RW_CTRL_ECC_ERR_EN`.
- **Defined:** in a cycle where `inflight` is set and `ram_ecc_err` is 1, set `err` sticky. If `err` was previously 0, also latch the fetched address into `err_addr`. Both clear only on reset. Data is still delivered unmodified.
- **Undefined:** `err=0` and `err_addr=0` constantly, and `ram_ecc_err` is ignored.

## Test plan
- **Latency on empty FIFO:** reset, then write 0xA5 once with `rd_ready=0` → `rd_valid` rises exactly 2 cycles after the accept edge, `rd_data=0xA5`, `level=1`.
- **Fill to capacity:** with DEPTH=8 and `rd_ready=0`, write 1..11 → `wr_ready` falls after the 11th accept, `level=11`, `ob_count=3`. Then drain with `rd_ready=1` → 1..11 come out in order and `level` returns to 0.
- **Wrap-around:** with DEPTH=5, stream 40 writes with `rd_ready` toggling 1,0 → output is 0..39 in order with no loss or duplication.
- **Mixed streaming:** assert `wr_valid` and `rd_ready` continuously → `ram_cs=1` every cycle, and `ram_we` alternates 1,0 in steady state.
- **Reset mid-operation:** assert `rst_n=0` for 1 cycle mid-stream with `level=6` → `level=0`, `rd_valid=0`. The next write of 0x3C is the next item read.
- **ECC error, macro defined:** pulse `ram_ecc_err` on the landing cycle of the fetch from address 4 → `err=1` and `err_addr=4`. A later error at address 6 leaves `err_addr=4`.

Source files
------------

// File: rtl/nx_ram_fifo_1rw_ctrl_if.sv
// ---------------------------------------------------------------------------
// nx_ram_fifo_1rw_ctrl_if
//   Valid/ready handshake bundle for the 1rw-RAM FIFO controller.
//
//   Signals:
//     wr_valid / wr_data / wr_ready : write (push) channel
//     rd_valid / rd_data / rd_ready : read (pop) channel
//
//   Modports:
//     master : the FIFO user (drives writes, consumes reads)
//     slave  : the FIFO controller
// ---------------------------------------------------------------------------
interface nx_ram_fifo_1rw_ctrl_if #(
    parameter int WIDTH = 64
) ();
    logic             wr_valid;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ready;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             rd_ready;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/nx_ram_fifo_1rw_ctrl.sv
// ---------------------------------------------------------------------------
// nx_ram_fifo_1rw_ctrl
//   Turns one single-port (1rw) RAM macro with a registered read port into a
//   valid/ready FIFO. Writes and prefetch reads share the RAM port; a 3-entry
//   output buffer hides the one-cycle read latency. Capacity is DEPTH+3.
//
//   Ports:
//     clk, rst_n      : clock (also clocks the RAM), async active-low reset
//     fifo (slave)    : wr_valid/wr_data/wr_ready, rd_valid/rd_data/rd_ready
//     level           : entries held (RAM + in-flight read + output buffer)
//     ram_cs, ram_we  : RAM strobes
//     ram_add         : RAM address
//     ram_din,ram_bwe : RAM write data, bit write enables (all ones)
//     ram_dout        : RAM registered read data
//     ram_ecc_err     : RAM uncorrectable-error flag
//     err, err_addr   : sticky error and address of the first errored read
//
//   Configuration:
//     NX_RAM_FIFO_1RW_CTRL_ECC_ERR_EN : when defined, ram_ecc_err on a
//     landing read sets err and captures err_addr. When undefined, err and
//     err_addr are tied to zero and ram_ecc_err is ignored.
// ---------------------------------------------------------------------------
module nx_ram_fifo_1rw_ctrl #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 32768,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nx_ram_fifo_1rw_ctrl_if.slave fifo,
    output logic [AW+1:0]        level,
    output logic                 ram_cs,
    output logic                 ram_we,
    output logic [AW-1:0]        ram_add,
    output logic [WIDTH-1:0]     ram_din,
    output logic [WIDTH-1:0]     ram_bwe,
    input  logic [WIDTH-1:0]     ram_dout,
    input  logic                 ram_ecc_err,
    output logic                 err,
    output logic [AW-1:0]        err_addr
);

    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {
        GNT_RD = 1'b0,
        GNT_WR = 1'b1
    } grant_e;

    grant_e           last_grant;
    grant_e           last_grant_nxt;

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      ram_count;
    logic             inflight;
    logic [1:0]       ob_count;
    logic [1:0]       ob_count_nxt;
    logic [WIDTH-1:0] ob_data     [3];
    logic [WIDTH-1:0] ob_data_nxt [3];
    logic [1:0]       wr_idx;

    logic             fetch_req;
    logic             urgent;
    logic             wr_grant;
    logic             rd_grant;
    logic             push;
    logic             pop;

    // Pointer increment with wrap at DEPTH-1 (DEPTH need not be a power of 2).
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + AW'(1);
    endfunction

    // ------------------------------------------------------------------
    // Request / grant
    // ------------------------------------------------------------------
    assign fetch_req = (ram_count != '0) &&
                       (({1'b0, ob_count} + {2'b00, inflight}) < 3'd3);
    assign urgent    = fetch_req && (ob_count == 2'd0) && !inflight;

    // Depends on state only, so no combinational path from wr_valid/rd_ready.
    assign fifo.wr_ready = (ram_count != FULL_CNT) &&
                           !(fetch_req && (urgent || (last_grant == GNT_WR)));

    assign wr_grant = fifo.wr_valid && fifo.wr_ready;
    assign rd_grant = fetch_req && !wr_grant;

    assign push = inflight;
    assign pop  = fifo.rd_valid && fifo.rd_ready;

    // ------------------------------------------------------------------
    // Arbiter: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GNT_RD;
        end else begin
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        last_grant_nxt = last_grant;
        if (wr_grant) begin
            last_grant_nxt = GNT_WR;
        end else if (rd_grant) begin
            last_grant_nxt = GNT_RD;
        end
    end

    always_comb begin
        ram_cs  = wr_grant || rd_grant;
        ram_we  = wr_grant;
        ram_add = wr_grant ? wptr : rptr;
        ram_din = fifo.wr_data;
        ram_bwe = '1;
    end

    // ------------------------------------------------------------------
    // RAM-side pointers and counters; read issue stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            ram_count <= '0;
            inflight  <= 1'b0;
        end else begin
            if (wr_grant) begin
                wptr      <= ptr_inc(wptr);
                ram_count <= ram_count + (AW+1)'(1);
            end else if (rd_grant) begin
                rptr      <= ptr_inc(rptr);
                ram_count <= ram_count - (AW+1)'(1);
            end
            inflight <= rd_grant;
        end
    end

    // ------------------------------------------------------------------
    // Landing stage: output buffer (shift toward head on pop)
    // ------------------------------------------------------------------
    always_comb begin
        ob_count_nxt = ob_count;
        if (push && !pop) begin
            ob_count_nxt = ob_count + 2'd1;
        end else if (!push && pop) begin
            ob_count_nxt = ob_count - 2'd1;
        end
    end

    always_comb begin
        ob_data_nxt = ob_data;
        wr_idx      = ob_count;
        if (pop) begin
            ob_data_nxt[0] = ob_data[1];
            ob_data_nxt[1] = ob_data[2];
            wr_idx         = ob_count - 2'd1;
        end
        if (push) begin
            for (int i = 0; i < 3; i++) begin
                if (wr_idx == 2'(i)) begin
                    ob_data_nxt[i] = ram_dout;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ob_count <= 2'd0;
        end else begin
            ob_count <= ob_count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            ob_data[i] <= ob_data_nxt[i];
        end
    end

    assign fifo.rd_valid = (ob_count != 2'd0);
    assign fifo.rd_data  = ob_data[0];

    assign level = (AW+2)'(ram_count) + (AW+2)'(inflight) + (AW+2)'(ob_count);

    // ------------------------------------------------------------------
    // Error capture on the landing stage
    // ------------------------------------------------------------------
`ifdef NX_RAM_FIFO_1RW_CTRL_ECC_ERR_EN
    logic [AW-1:0] fetch_addr_p1;

    always_ff @(posedge clk) begin
        if (rd_grant) begin
            fetch_addr_p1 <= rptr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err      <= 1'b0;
            err_addr <= '0;
        end else if (inflight && ram_ecc_err) begin
            err <= 1'b1;
            if (!err) begin
                err_addr <= fetch_addr_p1;
            end
        end
    end
`else
    logic unused_ecc_err;

    assign unused_ecc_err = ram_ecc_err;
    assign err            = 1'b0;
    assign err_addr       = '0;
`endif

endmodule
